// File: rtl/param_single_port_ram.sv
// Single-port synchronous RAM with byte enables, selectable read-during-write result,
// optional output register and optional zero-fill after reset.
module param_single_port_ram #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 6,
    parameter int unsigned RDW_MODE       = 0,
    parameter int unsigned OUT_REG        = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                    mem_clk,
    input  logic                    mem_rst,
    input  logic                    mem_req,
    input  logic                    mem_we,
    input  logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic [ADDR_WIDTH-1:0]   mc_address_mem,
    input  logic [DATA_WIDTH-1:0]   mem_data_in,
    output logic [DATA_WIDTH-1:0]   mem_data_out,
    output logic                    mem_rvalid,
    output logic                    mem_ready
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [DATA_WIDTH-1:0]   mem_array [DEPTH];

    logic                    accept_c;
    logic                    clear_we_c;
    logic [DATA_WIDTH-1:0]   old_word_c;
    logic [DATA_WIDTH-1:0]   merged_c;
    logic [DATA_WIDTH-1:0]   rsp_word_c;

    logic                    s1_valid;
    logic [DATA_WIDTH-1:0]   s1_data;

    // Reset overrides any request seen on the same edge.
    assign accept_c   = mem_req && mem_ready && !mem_rst;
    assign clear_we_c = (state == ST_CLEAR) && !mem_rst;
    assign old_word_c = mem_array[mc_address_mem];

    always_comb begin
        merged_c = old_word_c;
        for (int i = 0; i < NB; i++) begin
            if (mem_be[i]) begin
                merged_c[8*i +: 8] = mem_data_in[8*i +: 8];
            end
        end
    end

    // With mem_be=0 the merged word equals the old word, so both modes agree.
    assign rsp_word_c = (mem_we && (RDW_MODE == 0)) ? merged_c : old_word_c;

    // Control FSM: zero-fill sweep, then accept requests.
    always_ff @(posedge mem_clk) begin
        if (mem_rst) begin
            state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_cnt   <= '0;
            mem_ready <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    mem_ready <= 1'b0;
                    if (clr_cnt == '1) begin
                        state     <= ST_READY;
                        mem_ready <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
                    end
                end
                ST_READY: begin
                    mem_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_READY;
                    mem_ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; the fill sweep is the only way to zero it.
    always_ff @(posedge mem_clk) begin
        if (clear_we_c) begin
            mem_array[clr_cnt] <= '0;
        end else if (accept_c && mem_we) begin
            mem_array[mc_address_mem] <= merged_c;
        end
    end

    // First response stage, loaded on every accepted access.
    always_ff @(posedge mem_clk) begin
        if (mem_rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                s1_data <= rsp_word_c;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            always_ff @(posedge mem_clk) begin
                if (mem_rst) begin
                    mem_rvalid   <= 1'b0;
                    mem_data_out <= '0;
                end else begin
                    mem_rvalid <= s1_valid;
                    if (s1_valid) begin
                        mem_data_out <= s1_data;
                    end
                end
            end
        end else begin : g_no_out_reg
            assign mem_rvalid   = s1_valid;
            assign mem_data_out = s1_data;
        end
    endgenerate

endmodule
